// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants and FSM state encoding for the polynomial reducer.
package gf_pkg;

  localparam int unsigned GF_WIDTH = 8;
  localparam logic [8:0]  AES_POLY = 9'h11B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } gf_state_e;

endpackage

// File: rtl/gf_reduce_step.sv
// One long-division step: cancel bit idx_i with POLY aligned so its x^WIDTH term sits at idx_i.
module gf_reduce_step #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH:0]   POLY  = 9'h11B,
  localparam int unsigned     PW    = 2 * (WIDTH - 1) + 1,
  localparam int unsigned     IW    = $clog2(PW)
) (
  input  logic [PW-1:0] work_i,
  input  logic [IW-1:0] idx_i,
  output logic [PW-1:0] work_o
);

  logic [PW-1:0] poly_ext;
  logic [IW-1:0] shamt;

  assign poly_ext = PW'(POLY);
  assign shamt    = idx_i - IW'(WIDTH);

  always_comb begin
    work_o = work_i;
    // Indices below WIDTH are already inside the field and never get cancelled.
    if ((idx_i >= IW'(WIDTH)) && work_i[idx_i]) begin
      work_o = work_i ^ (poly_ext << shamt);
    end
  end

endmodule

// File: rtl/gf_poly_reduce.sv
// Sequential reduction of an unreduced GF(2) product modulo POLY, one bit per cycle.
// Optional feature macro GF_REDUCE_DEGREE_EN adds deg_out (degree of the accepted product).
module gf_poly_reduce
  import gf_pkg::*;
#(
  parameter int unsigned    WIDTH = GF_WIDTH,
  parameter logic [WIDTH:0] POLY  = (WIDTH + 1)'(AES_POLY)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*(WIDTH-1):0]   prod_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       rem_out,
  output logic                   busy
`ifdef GF_REDUCE_DEGREE_EN
  ,
  output logic [3:0]             deg_out
`endif
);

  localparam int unsigned PW = 2 * (WIDTH - 1) + 1;
  localparam int unsigned IW = $clog2(PW);

  gf_state_e     state_q, state_d;
  logic [PW-1:0] work_q, work_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] step_work;
  logic          accept;

  assign accept = in_valid && (state_q == IDLE);

  gf_reduce_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .work_i (work_q),
    .idx_i  (idx_q),
    .work_o (step_work)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = prod_in;
          idx_d   = IW'(PW - 1);
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        work_d = step_work;
        idx_d  = idx_q - 1'b1;
        // Bit WIDTH is the last one that can be cancelled; the result now fits the field.
        if (idx_q == IW'(WIDTH)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rem_out   = out_valid ? work_q[WIDTH-1:0] : '0;

`ifdef GF_REDUCE_DEGREE_EN
  logic [3:0] deg_q, deg_d;

  always_comb begin
    deg_d = '0;
    for (int b = 1; b < PW; b++) begin
      if (prod_in[b]) deg_d = 4'(b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deg_q <= '0;
    end else if (accept) begin
      deg_q <= deg_d;
    end
  end

  assign deg_out = deg_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gf_poly_reduce.sv
// Scoreboard bench for gf_poly_reduce: directed vectors, stall, abort and random traffic.
module tb_gf_poly_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] prod_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  rem_out;
  logic        busy;
`ifdef GF_REDUCE_DEGREE_EN
  logic [3:0]  deg_out;
`endif

  gf_poly_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_in   (prod_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rem_out   (rem_out),
    .busy      (busy)
`ifdef GF_REDUCE_DEGREE_EN
    ,
    .deg_out   (deg_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] p;
    logic [7:0]  rem;
    logic [3:0]  deg;
    int          acc;
  } item_t;

  item_t sbq[$];
  int passed = 0;
  int total  = 0;
  logic [7:0] xk [15];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Reference: p mod P as the XOR of x^k mod P over the set bits of p.
  function automatic logic [7:0] ref_mod(input logic [14:0] p);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 15; k++) if (p[k]) r ^= xk[k];
    return r;
  endfunction

  function automatic logic [3:0] ref_deg(input logic [14:0] p);
    int d = 0;
    for (int k = 0; k < 15; k++) if ((p >> k) != 0) d = k;
    return 4'(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] p, input logic [7:0] r);
    int w = 0;
    while (!in_ready && w < 100) begin
      in_valid  = 1'($urandom_range(0, 1));
      prod_in   = 15'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    prod_in  = p;
    sbq.push_back('{p: p, rem: r, deg: ref_deg(p), acc: cyc + 1});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 200) begin
      step();
      w++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Monitor: invariants every cycle, latency on rising out_valid, data on output handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      chk("busy_not_ready", {31'd0, busy}, {31'd0, ~in_ready});
      if (!out_valid) chk("rem_zero_invalid", {24'd0, rem_out}, 32'd0);
      if (out_valid) begin
        chk("unexpected_out", {31'd0, sbq.size() != 0}, 32'd1);
        if (sbq.size() != 0) begin
          if (!ov_prev) chk("latency", cyc - sbq[0].acc, 7);
          chk("rem_out", {24'd0, rem_out}, {24'd0, sbq[0].rem});
`ifdef GF_REDUCE_DEGREE_EN
          chk("deg_out", {28'd0, deg_out}, {28'd0, sbq[0].deg});
`endif
          if (out_ready) sbq.delete(0);
        end
      end
      ov_prev = out_valid && !out_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time bound at cycle %0d", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [8:0] v;
    v = 9'h001;
    for (int k = 0; k < 15; k++) begin
      xk[k] = v[7:0];
      v = v << 1;
      if (v[8]) v ^= 9'h11B;
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; prod_in = '0;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rem_out", {24'd0, rem_out}, 32'd0);
`ifdef GF_REDUCE_DEGREE_EN
    chk("rst_deg_out", {28'd0, deg_out}, 32'd0);
`endif
    rst = 1'b0;
    step();

    send(15'h2B79, 8'hC1);
    send(15'h0100, 8'h1B);
    send(15'h4000, 8'h9A);
    send(15'h00FF, 8'hFF);
    send(15'h0000, 8'h00);
    out_ready = 1'b1;
    drain();

    // Stall in DONE with a competing in_valid that must be ignored.
    out_ready = 1'b0;
    send(15'h0100, 8'h1B);
    begin
      int w = 0;
      while (!out_valid && w < 20) begin step(); w++; end
    end
    chk("stall_reach_done", {31'd0, out_valid}, 32'd1);
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rem", {24'd0, rem_out}, 32'h1B);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      prod_in  = 15'h4000;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);

    // Abort on the third REDUCE cycle; the dropped result must never appear.
    send(15'h2B79, 8'hC1);
    step();
    step();
    rst = 1'b1;
    sbq.delete(sbq.size() - 1);
    step();
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_rem_out", {24'd0, rem_out}, 32'd0);
    rst = 1'b0;
    repeat (12) step();
    send(15'h2B79, 8'hC1);
    drain();

    for (int n = 0; n < 1000; n++) begin
      logic [14:0] p;
      p = 15'($urandom);
      send(p, ref_mod(p));
    end
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gf_poly_reduce.md
GF_POLY_REDUCE -- requirements
Module: gf_poly_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 8: field element width in bits.
REQ-002 SHALL have parameter POLY, default 9'h11B: irreducible polynomial x^8+x^4+x^3+x+1, WIDTH+1 bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: prod_in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a product.
REQ-007 SHALL have port prod_in, input, 2*(WIDTH-1)+1 bits: unreduced polynomial product from galois_multiplication.
REQ-008 SHALL have port out_valid, output, 1 bit: rem_out is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port rem_out, output, WIDTH bits: prod_in mod POLY.
REQ-011 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, REDUCE and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an input handshake (in_valid && in_ready) SHALL load prod_in into the work register, set bit index i = 2*(WIDTH-1) and move the FSM to REDUCE.
REQ-014 On each REDUCE cycle, if work[i]==1, work SHALL become work ^ (POLY << (i-WIDTH)); i SHALL then decrement by 1.
REQ-015 After processing i==WIDTH, the FSM SHALL move to DONE, giving exactly WIDTH-1 REDUCE cycles.
REQ-016 out_valid SHALL rise WIDTH-1 clock edges after the input-handshake edge (7 for WIDTH=8), independent of the data.
REQ-017 In DONE: out_valid SHALL be 1 and rem_out SHALL equal work[WIDTH-1:0]; both SHALL stay stable while out_ready is 0.
REQ-018 An output handshake (out_valid && out_ready) SHALL return the FSM to IDLE; in_ready SHALL be 1 on the next cycle.
REQ-019 The block SHALL NOT overlap transactions; minimum initiation interval is WIDTH+1 cycles.
REQ-020 in_valid outside IDLE SHALL be ignored, with no capture and no state change.
REQ-021 A zero product SHALL still take the full latency and return 0.
REQ-022 rem_out SHALL be 0 whenever out_valid is 0.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst SHALL put the FSM in IDLE and clear work, i, out_valid, rem_out and busy to 0.
REQ-025 After rst, in_ready SHALL be 1.
REQ-026 rst asserted in REDUCE or DONE SHALL abort the transaction with no output; the aborted result SHALL never appear.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-028 With GF_REDUCE_DEGREE_EN defined, the block SHALL add output deg_out, 4 bits.
REQ-029 deg_out SHALL be captured at the input handshake as the index of the highest set bit of prod_in, or 0 if prod_in is 0 or 1.
REQ-030 deg_out SHALL be held until the next handshake and cleared by rst.
REQ-031 Without GF_REDUCE_DEGREE_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package gf_pkg SHALL hold the AES_POLY constant (9'h11B), the GF_WIDTH default (8) and the FSM state encoding type.
REQ-033 One combinational sub-module, gf_reduce_step, SHALL perform the conditional shifted XOR of a single bit index; the top SHALL hold only the FSM, the counter and the registers.

Verification
REQ-034 After reset: prod_in=15'h2B79 (57*83 unreduced) -> out_valid 7 edges after accept, rem_out=8'hC1; deg_out=13 if enabled.
REQ-035 prod_in=15'h0100 -> rem_out=8'h1B; prod_in=15'h4000 -> rem_out=8'h9A; prod_in=15'h00FF -> rem_out=8'hFF with full 7-cycle latency.
REQ-036 prod_in=0 -> rem_out=8'h00 after 7 cycles; deg_out=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid and rem_out stable, in_ready=0, and a new in_valid is ignored; then out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-038 Assert rst on the 3rd REDUCE cycle -> next cycle out_valid=0, busy=0, in_ready=1, and no stale result appears; a following transaction 15'h2B79 yields 8'hC1.
REQ-039 Random products, 1000 back-to-back transactions, compared against a software mod-0x11B model -> zero mismatches.
